// File: rtl/mul_seq64_if.sv
// Operand/result bundle between the execute stage and the sequential multiplier.
interface mul_seq64_if #(
    parameter int W = 64
);
    logic         Start;
    logic         Signed;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] ResultLo;
    logic [W-1:0] ResultHi;

    modport master (
        output Start, Signed, A, B,
        input  Busy, Done, ResultLo, ResultHi
    );

    modport slave (
        input  Start, Signed, A, B,
        output Busy, Done, ResultLo, ResultHi
    );
endinterface

// File: rtl/mul_seq64.sv
// Sequential shift-add multiplier: W iterations on operand magnitudes,
// sign applied once at the end, registered Done strobe and result halves.
module mul_seq64 #(
    parameter int W = 64
) (
    input  logic        CLK,
    input  logic        Reset,
    mul_seq64_if.slave  bus
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t         state;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  count;
    logic           neg;

    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     add_sum;
    logic [2*W-1:0] acc_step;
    logic [2*W-1:0] acc_final;

    // Operand magnitudes, one shift-add step and final sign fix-up.
    always_comb begin
        mag_a     = bus.A;
        mag_b     = bus.B;
        add_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, mcand};
        acc_step  = {1'b0, acc[2*W-1:1]};
        acc_final = acc;
        if (bus.Signed && bus.A[W-1]) begin
            mag_a = ~bus.A + W'(1);
        end
        if (bus.Signed && bus.B[W-1]) begin
            mag_b = ~bus.B + W'(1);
        end
        if (mplier[0]) begin
            acc_step = {add_sum, acc[W-1:1]};
        end
        if (neg) begin
            acc_final = ~acc + (2*W)'(1);
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            count        <= '0;
            neg          <= 1'b0;
            bus.Busy     <= 1'b0;
            bus.Done     <= 1'b0;
            bus.ResultLo <= '0;
            bus.ResultHi <= '0;
        end else begin
            bus.Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        mcand    <= mag_a;
                        mplier   <= mag_b;
                        neg      <= bus.Signed & (bus.A[W-1] ^ bus.B[W-1]);
                        acc      <= '0;
                        count    <= '0;
                        bus.Busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_step;
                    mplier <= {1'b0, mplier[W-1:1]};
                    count  <= count + CW'(1);
                    if (count == LAST) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bus.ResultLo <= acc_final[W-1:0];
                    bus.ResultHi <= acc_final[2*W-1:W];
                    bus.Done     <= 1'b1;
                    bus.Busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq64.sv
// Directed self-checking bench for mul_seq64.
module tb_mul_seq64;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    mul_seq64_if #(.W(64)) bus ();

    mul_seq64 dut (
        .CLK   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands on a negedge; return just after the accepting posedge.
    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic sgn);
        @(negedge clk);
        bus.Start  = 1'b1;
        bus.A      = a;
        bus.B      = b;
        bus.Signed = sgn;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
    endtask

    // Count edges until Done is seen; also report whether Busy stayed high before it.
    task automatic wait_done(output int edges, output bit busy_ok);
        edges   = 0;
        busy_ok = 1'b1;
        while (edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.Done) break;
            if (!bus.Busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.Start  = 1'b0;
        bus.Signed = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        repeat (3) @(posedge clk);
        #1;
        if (bus.Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %0b want 0", bus.Busy); end
        compared++;
        if (bus.Done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got %0b want 0", bus.Done); end
        compared++;
        if (bus.ResultLo !== 64'd0) begin mismatched++; $display("[TB] FAIL reset_lo got %h want 0", bus.ResultLo); end
        compared++;
        if (bus.ResultHi !== 64'd0) begin mismatched++; $display("[TB] FAIL reset_hi got %h want 0", bus.ResultHi); end
        compared++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned_small();
        int edges;
        bit busy_ok;
        start_op(64'd3, 64'd5, 1'b0);
        if (bus.Busy !== 1'b1) begin mismatched++; $display("[TB] FAIL small_busy_rise got %0b want 1", bus.Busy); end
        compared++;
        wait_done(edges, busy_ok);
        if (edges !== 65) begin mismatched++; $display("[TB] FAIL small_latency got %0d want 65", edges); end
        compared++;
        if (busy_ok !== 1'b1) begin mismatched++; $display("[TB] FAIL small_busy_held got %0b want 1", busy_ok); end
        compared++;
        if (bus.Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL small_busy_fall got %0b want 0", bus.Busy); end
        compared++;
        if (bus.ResultLo !== 64'd15) begin mismatched++; $display("[TB] FAIL small_lo got %h want f", bus.ResultLo); end
        compared++;
        if (bus.ResultHi !== 64'd0) begin mismatched++; $display("[TB] FAIL small_hi got %h want 0", bus.ResultHi); end
        compared++;
        @(posedge clk);
        #1;
        if (bus.Done !== 1'b0) begin mismatched++; $display("[TB] FAIL small_done_strobe got %0b want 0", bus.Done); end
        compared++;
        if (bus.ResultLo !== 64'd15) begin mismatched++; $display("[TB] FAIL small_lo_hold got %h want f", bus.ResultLo); end
        compared++;
    endtask

    task automatic test_unsigned_max();
        int edges;
        bit busy_ok;
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        wait_done(edges, busy_ok);
        if (edges !== 65) begin mismatched++; $display("[TB] FAIL max_latency got %0d want 65", edges); end
        compared++;
        if (bus.ResultHi !== 64'hFFFF_FFFF_FFFF_FFFE) begin mismatched++; $display("[TB] FAIL max_hi got %h want fffffffffffffffe", bus.ResultHi); end
        compared++;
        if (bus.ResultLo !== 64'h0000_0000_0000_0001) begin mismatched++; $display("[TB] FAIL max_lo got %h want 1", bus.ResultLo); end
        compared++;
    endtask

    task automatic test_signed();
        logic [63:0] a_tab  [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 64'h8000_0000_0000_0000};
        logic [63:0] b_tab  [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] hi_tab [3] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        logic [63:0] lo_tab [3] = '{64'd1, 64'hFFFF_FFFF_FFFF_FFEB, 64'h8000_0000_0000_0000};
        int edges;
        bit busy_ok;
        for (int i = 0; i < 3; i++) begin
            start_op(a_tab[i], b_tab[i], 1'b1);
            wait_done(edges, busy_ok);
            if (edges !== 65) begin mismatched++; $display("[TB] FAIL signed%0d_latency got %0d want 65", i, edges); end
            compared++;
            if (bus.ResultHi !== hi_tab[i]) begin mismatched++; $display("[TB] FAIL signed%0d_hi got %h want %h", i, bus.ResultHi, hi_tab[i]); end
            compared++;
            if (bus.ResultLo !== lo_tab[i]) begin mismatched++; $display("[TB] FAIL signed%0d_lo got %h want %h", i, bus.ResultLo, lo_tab[i]); end
            compared++;
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        bit busy_ok;
        start_op(64'd6, 64'd7, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.A     = 64'd9;
        bus.B     = 64'd9;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        if (bus.Busy !== 1'b1) begin mismatched++; $display("[TB] FAIL ignored_busy got %0b want 1", bus.Busy); end
        compared++;
        wait_done(edges, busy_ok);
        if (edges + 10 !== 65) begin mismatched++; $display("[TB] FAIL ignored_latency got %0d want 65", edges + 10); end
        compared++;
        if (bus.ResultLo !== 64'd42) begin mismatched++; $display("[TB] FAIL ignored_lo got %h want 2a", bus.ResultLo); end
        compared++;
        bus.Start = 1'b1;
        bus.A     = 64'd9;
        bus.B     = 64'd9;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        if (bus.Busy !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_accept got %0b want 1", bus.Busy); end
        compared++;
        wait_done(edges, busy_ok);
        if (edges !== 65) begin mismatched++; $display("[TB] FAIL b2b_latency got %0d want 65", edges); end
        compared++;
        if (bus.ResultLo !== 64'd81) begin mismatched++; $display("[TB] FAIL b2b_lo got %h want 51", bus.ResultLo); end
        compared++;
    endtask

    task automatic test_reset_mid_run();
        int edges;
        bit busy_ok;
        bit seen_done;
        start_op(64'd2, 64'd2, 1'b0);
        wait_done(edges, busy_ok);
        if (bus.ResultLo !== 64'd4) begin mismatched++; $display("[TB] FAIL pre_reset_lo got %h want 4", bus.ResultLo); end
        compared++;
        start_op(64'd5, 64'd5, 1'b0);
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        if (bus.Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy got %0b want 0", bus.Busy); end
        compared++;
        if (bus.Done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_done got %0b want 0", bus.Done); end
        compared++;
        if (bus.ResultLo !== 64'd0) begin mismatched++; $display("[TB] FAIL midrst_lo got %h want 0", bus.ResultLo); end
        compared++;
        if (bus.ResultHi !== 64'd0) begin mismatched++; $display("[TB] FAIL midrst_hi got %h want 0", bus.ResultHi); end
        compared++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (bus.Done) seen_done = 1'b1;
        end
        if (seen_done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_stray_done got %0b want 0", seen_done); end
        compared++;
        start_op(64'd4, 64'd4, 1'b0);
        wait_done(edges, busy_ok);
        if (edges !== 65) begin mismatched++; $display("[TB] FAIL postrst_latency got %0d want 65", edges); end
        compared++;
        if (bus.ResultLo !== 64'd16) begin mismatched++; $display("[TB] FAIL postrst_lo got %h want 10", bus.ResultLo); end
        compared++;
    endtask

    task automatic test_operand_stability();
        int edges;
        start_op(64'd10, 64'd10, 1'b0);
        edges = 0;
        while (edges < 200) begin
            @(negedge clk);
            bus.A      = {$urandom, $urandom};
            bus.B      = {$urandom, $urandom};
            bus.Signed = 1'($urandom);
            @(posedge clk);
            #1;
            edges++;
            if (bus.Done) break;
        end
        if (edges !== 65) begin mismatched++; $display("[TB] FAIL stable_latency got %0d want 65", edges); end
        compared++;
        if (bus.ResultLo !== 64'd100) begin mismatched++; $display("[TB] FAIL stable_lo got %h want 64", bus.ResultLo); end
        compared++;
        if (bus.ResultHi !== 64'd0) begin mismatched++; $display("[TB] FAIL stable_hi got %h want 0", bus.ResultHi); end
        compared++;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_unsigned_small();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_reset_mid_run();
        test_operand_stability();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mul_seq64.md
# mul_seq64

Sequential 64-bit integer multiplier sitting directly upstream of the 64-bit pipeline register banks in the execute stage. It accepts two operands on a start pulse and iterates one shift-add step per clock. It then presents the 128-bit product as two 64-bit halves with a one-cycle `Done` strobe. `Done` and the result halves wire straight into the `Eneable` and `D` inputs of the downstream register banks, which capture the product.

## Interface
- `W`, 64, operand width; product is 2·W bits split into two W-bit halves.

- `CLK`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request; sampled only when `Busy`=0.
- `Signed`  in  1  1 = two's-complement operands, 0 = unsigned; latched with operands.
- `A`  in  W  multiplicand; latched on accepted `Start`.
- `B`  in  W  multiplier; latched on accepted `Start`.
- `Busy`  out  1  high while an operation is in flight.
- `Done`  out  1  one-cycle strobe; result halves valid and new in this cycle.
- `ResultLo`  out  W  product bits [W-1:0].
- `ResultHi`  out  W  product bits [2W-1:W].

## Operation
- FSM states: IDLE, RUN, FINISH.
- IDLE: `Busy`=0. `Start`=1 at a rising edge performs the following and moves to RUN:
  - latches `Signed`;
  - latches |A| and |B| (magnitudes when `Signed`=1, raw values otherwise);
  - records the sign flag as sign(A) XOR sign(B), forced to 0 when unsigned;
  - clears the 2W-bit accumulator;
  - clears the iteration counter.
- RUN, one step per edge:
  - if the multiplier LSB is 1, add the multiplicand (aligned to the upper half) into the accumulator, keeping the carry;
  - shift the {carry, accumulator} pair and the multiplier right by 1;
  - increment the counter.
- RUN ends after exactly W steps, when the counter reaches W-1, and moves to FINISH.
- Latency is fixed: no early exit on zero operands.
- FINISH, one edge:
  - if the sign flag is set, load the 2W-bit two's complement of the accumulator into `ResultHi`/`ResultLo`; otherwise load it unchanged;
  - set `Done`=1 and return to IDLE.
- `Done` is registered. It is high exactly one cycle, coinciding with the first cycle IDLE is re-entered.
- `ResultHi`/`ResultLo` change only on the FINISH edge and hold until the next FINISH.
- `Start` while `Busy`=1 is ignored: no queuing, operands not re-latched.
- `Start` during the `Done` cycle is accepted, since `Busy`=0 (back-to-back operation).
- A/B/Signed changes after acceptance have no effect.
- Edge case: -2^(W-1) has magnitude 2^(W-1), which fits in W unsigned bits. No overflow case exists; the 2W-bit result is always exact.
- Reset asserted (low), at any time including mid-RUN, immediately forces:
  - state IDLE, counter 0;
  - `Busy`=0, `Done`=0;
  - `ResultLo`=`ResultHi`=0;
  - internal operand/accumulator registers cleared.
- An operation in flight when reset is asserted is discarded and produces no `Done`.

## Timing
- Reset values: `Busy`=0, `Done`=0, `ResultLo`=0, `ResultHi`=0.
- `Start` accepted at edge t:
  - `Busy`=1 from after t until edge t+W+1;
  - RUN steps occupy edges t+1 … t+W;
  - FINISH at edge t+W+1 updates the results;
  - `Done`=1 between edges t+W+1 and t+W+2.
- Start-to-`Done` latency is W+1 edges (65 for W=64). Throughput is one product per W+1 cycles with back-to-back starts.
- `Busy` falls in the same cycle `Done` rises.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset release is synchronous-safe: the first edge after deassertion may accept `Start`.

## Test plan
- Unsigned 3 × 5, `Signed`=0, `Start` at edge t -> `Done` only in cycle after edge t+65; `ResultLo`=15, `ResultHi`=0; `Busy` high for edges t+1…t+65.
- Unsigned 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF -> `ResultHi`=0xFFFF_FFFF_FFFF_FFFE, `ResultLo`=0x0000_0000_0000_0001.
- Signed cases:
  - -1 × -1 -> `ResultHi`=0, `ResultLo`=1;
  - -7 × 3 -> `ResultHi`=0xFFFF_FFFF_FFFF_FFFF, `ResultLo`=0xFFFF_FFFF_FFFF_FFEB;
  - 0x8000_0000_0000_0000 × -1 -> `ResultHi`=0, `ResultLo`=0x8000_0000_0000_0000.
- Start 6×7; pulse `Start` with A=B=9 at step 10 -> second `Start` ignored, result 42. Then issue 9×9 in the `Done` cycle -> accepted; second `Done` 65 edges later with 81.
- Complete 2×2 (result 4); start 5×5, drop `Reset` low at step 30 for 2 cycles -> `Busy`, `Done`, `ResultLo`, `ResultHi` all 0 immediately. No `Done` appears afterwards; a new 4×4 yields 16 with normal latency.
- Operand-stability case: start 10×10, then change A, B and `Signed` every cycle during RUN -> result 100, `Done` at nominal latency.
